div_unit: RTL and testbench

//  Iterative signed 32-bit divider for DIV instruction. Produces quotient (LO) and

---
 rtl/div_if.sv | 25 ++
 rtl/div_unit.sv | 101 ++++++++++
 tb/tb_div_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Divider handshake bundle: start/operands from the control unit, status/results back.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             div_busy;
  logic             div_done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  // control unit side
  modport master (
    output div_start, dividend, divisor,
    input  div_busy, div_done, div_zero, hi_out, lo_out
  );

  // divider side
  modport slave (
    input  div_start, dividend, divisor,
    output div_busy, div_done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/div_unit.sv
// Iterative signed restoring divider: one quotient bit per cycle on operand
// magnitudes, signs re-applied in a final fix-up cycle. LO = quotient, HI = remainder.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  div_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, rem, dmag;
  logic [WIDTH-1:0] rem_sh;
  logic             step_ge;
  logic             sign_a, sign_b;
  logic             zero;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi, lo;
  logic             busy, done;

  // Shift next dividend bit into the partial remainder. rem < |divisor| <= 2^(W-1),
  // so the shift never loses a set bit.
  assign rem_sh  = {rem[WIDTH-2:0], q[WIDTH-1]};
  assign step_ge = (rem_sh >= dmag);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: zero divisor skips straight to DONE; RUN leaves after the count==0 step
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.div_start) state_nxt = (bus.divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == '0)     state_nxt = FIX;
      FIX:                     state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, FIX: busy = 1'b1;
      DONE:     done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, restoring steps, sign fix-up into HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= '0;
      rem    <= '0;
      dmag   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      zero   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.div_start) begin
          sign_a <= bus.dividend[WIDTH-1];
          sign_b <= bus.divisor[WIDTH-1];
          // -2^(W-1) negates to itself, which is the right unsigned magnitude
          q      <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
          dmag   <= bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
          rem    <= '0;
          cnt    <= CNT_W'(WIDTH - 1);
          zero   <= (bus.divisor == '0);
        end
        RUN: begin
          rem <= step_ge ? (rem_sh - dmag) : rem_sh;
          q   <= {q[WIDTH-2:0], step_ge};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          lo <= (sign_a ^ sign_b) ? -q : q;
          hi <= sign_a ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

  assign bus.div_busy = busy;
  assign bus.div_done = done;
  assign bus.div_zero = zero;
  assign bus.hi_out   = hi;
  assign bus.lo_out   = lo;
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus random operands against an
// arithmetic reference (truncating signed division).
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;
  logic [W-1:0] prev_lo = '0, prev_hi = '0;

  always #5 clk = ~clk;

  div_if #(.WIDTH(W)) bus ();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed truncating division, remainder follows dividend.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = 'x; r = 'x;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  // Present a start pulse for one edge; returns at the negedge of cycle 1.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.div_start = 1'b1;
    @(negedge clk);
    bus.div_start = 1'b0;
  endtask

  // Wait for done (bounded), checking latency, results, flag and HI/LO stability.
  task automatic wait_done(input string tag, input int n0, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    int n = n0;
    bit stable = 1'b1;
    bit busy_seen = 1'b0;
    bit zdiv = (b == '0);
    logic [W-1:0] eq, er;
    ref_div(a, b, eq, er);
    while (!bus.div_done && n < 200) begin
      if (bus.hi_out !== prev_hi || bus.lo_out !== prev_lo) stable = 1'b0;
      if (bus.div_busy) busy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, W'(n), zdiv ? W'(1) : W'(W + 2));
    chk({tag, " stable"}, W'(stable), W'(1));
    chk({tag, " busy@done"}, W'(bus.div_busy), '0);
    chk({tag, " zero"}, W'(bus.div_zero), W'(zdiv));
    if (zdiv) begin
      chk({tag, " busy_seen"}, W'(busy_seen), '0);
    end else begin
      prev_lo = eq;
      prev_hi = er;
    end
    chk({tag, " lo"}, bus.lo_out, prev_lo);
    chk({tag, " hi"}, bus.hi_out, prev_hi);
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(a, b);
    wait_done(tag, 1, a, b);
  endtask

  initial begin
    int n;
    bit seen_done;
    logic [W-1:0] a, b;
    bus.div_start = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst busy", W'(bus.div_busy), '0);
    chk("rst done", W'(bus.div_done), '0);
    chk("rst zero", W'(bus.div_zero), '0);
    chk("rst hi", bus.hi_out, '0);
    chk("rst lo", bus.lo_out, '0);

    // basic and sign combinations
    run_div("100/7", 32'd100, 32'd7);
    chk("100/7 lo const", bus.lo_out, 32'd14);
    chk("100/7 hi const", bus.hi_out, 32'd2);
    run_div("5/0", 32'd5, 32'd0);
    chk("5/0 lo held", bus.lo_out, 32'd14);
    chk("5/0 hi held", bus.hi_out, 32'd2);
    run_div("-100/7", -32'sd100, 32'd7);
    chk("-100/7 lo const", bus.lo_out, 32'hFFFF_FFF2);
    chk("-100/7 hi const", bus.hi_out, 32'hFFFF_FFFE);
    run_div("100/-7", 32'd100, -32'sd7);
    run_div("-100/-7", -32'sd100, -32'sd7);
    run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf lo const", bus.lo_out, 32'h8000_0000);
    chk("ovf hi const", bus.hi_out, 32'h0);
    chk("ovf zero", W'(bus.div_zero), '0);
    run_div("3/10", 32'd3, 32'd10);
    run_div("min/min", 32'h8000_0000, 32'h8000_0000);
    run_div("7/min", 32'd7, 32'h8000_0000);

    // start while busy is ignored
    start_op(32'd1000, 32'd3);
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    bus.dividend  = 32'd50;
    bus.divisor   = 32'd5;
    bus.div_start = 1'b1;
    @(negedge clk);
    bus.div_start = 1'b0;
    n++;
    wait_done("restart", n, 32'd1000, 32'd3);
    chk("restart lo const", bus.lo_out, 32'd333);

    // reset mid-operation aborts with no done pulse
    start_op(32'd1000, 32'd3);
    n = 1;
    while (n < 20) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", W'(bus.div_busy), '0);
    chk("abort done", W'(bus.div_done), '0);
    chk("abort zero", W'(bus.div_zero), '0);
    chk("abort hi", bus.hi_out, '0);
    chk("abort lo", bus.lo_out, '0);
    prev_lo = '0;
    prev_hi = '0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_done || bus.div_busy) seen_done = 1'b1;
    end
    chk("abort quiet", W'(seen_done), '0);
    run_div("9/4", 32'd9, 32'd4);

    // random operands, biased toward zero/small divisors and extreme values
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = W'($signed($urandom_range(0, 20)) - 10);
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_div("rand", a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
